// File: rtl/load_store_unit_if.sv
// Request/response and memory-bus signals of the load/store unit.
// The unit itself binds to the slave modport; the core/memory side binds to master.
interface load_store_unit_if #(
    parameter int ADDR_WIDTH = 64,
    parameter int DATA_WIDTH = 64
);
    logic                  req_valid_in;
    logic                  req_ready_out;
    logic                  is_store_in;
    logic [2:0]            funct3_in;
    logic [ADDR_WIDTH-1:0] addr_in;
    logic [DATA_WIDTH-1:0] store_data_in;
    logic                  resp_valid_out;
    logic [DATA_WIDTH-1:0] load_data_out;
    logic                  error_out;
    logic [ADDR_WIDTH-1:0] mem_address_out;
    logic [DATA_WIDTH-1:0] mem_data_out;
    logic                  mem_writeEnable_out;
    logic                  mem_readEnable_out;
    logic [DATA_WIDTH-1:0] mem_data_in;

    modport slave (
        input  req_valid_in, is_store_in, funct3_in, addr_in, store_data_in, mem_data_in,
        output req_ready_out, resp_valid_out, load_data_out, error_out,
               mem_address_out, mem_data_out, mem_writeEnable_out, mem_readEnable_out
    );

    modport master (
        output req_valid_in, is_store_in, funct3_in, addr_in, store_data_in, mem_data_in,
        input  req_ready_out, resp_valid_out, load_data_out, error_out,
               mem_address_out, mem_data_out, mem_writeEnable_out, mem_readEnable_out
    );
endinterface

// File: rtl/load_store_unit.sv
// Load/store unit driving a word-wide data memory; sub-word stores are read-modify-write.
// Define LSU_MISALIGN_CHECK_EN to reject misaligned accesses; otherwise the offset is masked to the access size.
module load_store_unit #(
    parameter int ADDR_WIDTH      = 64,
    parameter int DATA_WIDTH      = 64,
    parameter int WORD_BYTES_2POW = 3
) (
    input  logic             clk_in,
    input  logic             reset_n,
    load_store_unit_if.slave lsu
);
    localparam int OFF_W = WORD_BYTES_2POW;

    typedef enum logic [2:0] {
        IDLE,
        DECODE,
        READ,
        CAPTURE,
        WRITE,
        RESP
    } state_t;

    state_t                state_q;
    logic                  isStore_q;
    logic [2:0]            funct3_q;
    logic [ADDR_WIDTH-1:0] addr_q;
    logic [DATA_WIDTH-1:0] storeData_q;
    logic                  reqReady_q;
    logic                  respValid_q;
    logic                  error_q;
    logic                  memWe_q;
    logic                  memRe_q;
    logic [DATA_WIDTH-1:0] loadData_q;
    logic [DATA_WIDTH-1:0] memData_q;
    logic [ADDR_WIDTH-1:0] memAddr_q;

    logic [OFF_W-1:0]      sizeMask_d;
    logic [OFF_W-1:0]      offset_d;
    logic                  illegal_d;
    logic                  error_d;
    logic                  isDouble_d;
    logic [ADDR_WIDTH-1:0] wordAddr_d;
    logic [DATA_WIDTH-1:0] shifted_d;
    logic [DATA_WIDTH-1:0] loadResult_d;
    logic [DATA_WIDTH-1:0] laneMask_d;
    logic [DATA_WIDTH-1:0] mergedWord_d;

    // Decode, lane extraction and store merge all work off the latched request fields.
    always_comb begin
        sizeMask_d = OFF_W'((1 << funct3_q[1:0]) - 1);
        illegal_d  = isStore_q ? funct3_q[2] : (funct3_q == 3'b111);
`ifdef LSU_MISALIGN_CHECK_EN
        error_d    = illegal_d | (|(addr_q[OFF_W-1:0] & sizeMask_d));
        offset_d   = addr_q[OFF_W-1:0];
`else
        error_d    = illegal_d;
        offset_d   = addr_q[OFF_W-1:0] & ~sizeMask_d;
`endif
        isDouble_d = (funct3_q[1:0] == 2'b11);
        wordAddr_d = {addr_q[ADDR_WIDTH-1:OFF_W], {OFF_W{1'b0}}};
        shifted_d  = lsu.mem_data_in >> {offset_d, 3'b000};

        loadResult_d = shifted_d;
        case (funct3_q[1:0])
            2'b00:   loadResult_d = {{(DATA_WIDTH-8){~funct3_q[2] & shifted_d[7]}}, shifted_d[7:0]};
            2'b01:   loadResult_d = {{(DATA_WIDTH-16){~funct3_q[2] & shifted_d[15]}}, shifted_d[15:0]};
            2'b10:   loadResult_d = {{(DATA_WIDTH-32){~funct3_q[2] & shifted_d[31]}}, shifted_d[31:0]};
            default: loadResult_d = shifted_d;
        endcase

        laneMask_d   = {DATA_WIDTH{1'b1}} >> (DATA_WIDTH - (8 << funct3_q[1:0]));
        laneMask_d   = laneMask_d << {offset_d, 3'b000};
        mergedWord_d = (lsu.mem_data_in & ~laneMask_d)
                     | ((storeData_q << {offset_d, 3'b000}) & laneMask_d);
    end

    always_ff @(posedge clk_in or negedge reset_n) begin
        if (!reset_n) begin
            state_q     <= IDLE;
            isStore_q   <= 1'b0;
            funct3_q    <= 3'b000;
            addr_q      <= '0;
            storeData_q <= '0;
            reqReady_q  <= 1'b1;
            respValid_q <= 1'b0;
            error_q     <= 1'b0;
            memWe_q     <= 1'b0;
            memRe_q     <= 1'b0;
            loadData_q  <= '0;
            memData_q   <= '0;
            memAddr_q   <= '0;
        end else begin
            respValid_q <= 1'b0;
            memWe_q     <= 1'b0;
            case (state_q)
                IDLE: begin
                    if (lsu.req_valid_in && reqReady_q) begin
                        isStore_q   <= lsu.is_store_in;
                        funct3_q    <= lsu.funct3_in;
                        addr_q      <= lsu.addr_in;
                        storeData_q <= lsu.store_data_in;
                        reqReady_q  <= 1'b0;
                        state_q     <= DECODE;
                    end
                end
                DECODE: begin
                    if (error_d) begin
                        error_q     <= 1'b1;
                        respValid_q <= 1'b1;
                        state_q     <= RESP;
                    end else if (isStore_q && isDouble_d) begin
                        memAddr_q <= wordAddr_d;
                        memData_q <= storeData_q;
                        memWe_q   <= 1'b1;
                        state_q   <= WRITE;
                    end else begin
                        memAddr_q <= wordAddr_d;
                        memRe_q   <= 1'b1;
                        state_q   <= READ;
                    end
                end
                READ: begin
                    state_q <= CAPTURE;
                end
                // Read data is valid at the end of CAPTURE; merge or extract straight from the bus.
                CAPTURE: begin
                    memRe_q <= 1'b0;
                    if (isStore_q) begin
                        memData_q <= mergedWord_d;
                        memWe_q   <= 1'b1;
                        state_q   <= WRITE;
                    end else begin
                        loadData_q  <= loadResult_d;
                        respValid_q <= 1'b1;
                        state_q     <= RESP;
                    end
                end
                WRITE: begin
                    respValid_q <= 1'b1;
                    state_q     <= RESP;
                end
                RESP: begin
                    error_q    <= 1'b0;
                    loadData_q <= '0;
                    reqReady_q <= 1'b1;
                    state_q    <= IDLE;
                end
                default: begin
                    reqReady_q <= 1'b1;
                    state_q    <= IDLE;
                end
            endcase
        end
    end

    assign lsu.req_ready_out       = reqReady_q;
    assign lsu.resp_valid_out      = respValid_q;
    assign lsu.load_data_out       = loadData_q;
    assign lsu.error_out           = error_q;
    assign lsu.mem_address_out     = memAddr_q;
    assign lsu.mem_data_out        = memData_q;
    assign lsu.mem_writeEnable_out = memWe_q;
    assign lsu.mem_readEnable_out  = memRe_q;
endmodule

// File: tb/tb_load_store_unit.sv
// Self-checking bench for load_store_unit: directed cases plus random requests
// checked against a byte-addressed reference memory.
module tb_load_store_unit;
    logic        clk;
    logic        rstN;
    int          checks;
    int          errors;
    logic [63:0] dutMem [0:31];
    logic [7:0]  refBytes [0:255];
    logic        preloadEn;
    logic [4:0]  preloadIdx;
    logic [63:0] preloadVal;

    load_store_unit_if lsuBus ();

    load_store_unit dut (
        .clk_in  (clk),
        .reset_n (rstN),
        .lsu     (lsuBus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Word memory with asynchronous read and clocked write; preload uses the same write port.
    assign lsuBus.mem_data_in = dutMem[lsuBus.mem_address_out[7:3]];
    always @(posedge clk) begin
        if (lsuBus.mem_writeEnable_out)
            dutMem[lsuBus.mem_address_out[7:3]] <= lsuBus.mem_data_out;
        else if (preloadEn)
            dutMem[preloadIdx] <= preloadVal;
    end

    task automatic checkOutput(input string tag, input logic [63:0] observed, input logic [63:0] expected);
        checks++;
        if (observed !== expected) begin
            errors++;
            $display("[TB] FAIL %s: observed 0x%0h, expected 0x%0h", tag, observed, expected);
        end
    endtask

    function automatic logic [63:0] refWord(input int idx);
        logic [63:0] w;
        w = '0;
        for (int i = 0; i < 8; i++) w |= 64'(refBytes[idx * 8 + i]) << (8 * i);
        return w;
    endfunction

    task automatic loadWord(input int idx, input logic [63:0] value);
        preloadIdx = idx[4:0];
        preloadVal = value;
        preloadEn  = 1'b1;
        @(posedge clk);
        #1 preloadEn = 1'b0;
        for (int i = 0; i < 8; i++) refBytes[idx * 8 + i] = value[8 * i +: 8];
        @(negedge clk);
    endtask

    task automatic checkIdleOutputs();
        checkOutput("idleReady", 64'(lsuBus.req_ready_out), 64'd1);
        checkOutput("idleResp", 64'(lsuBus.resp_valid_out), 64'd0);
        checkOutput("idleError", 64'(lsuBus.error_out), 64'd0);
        checkOutput("idleLoadData", lsuBus.load_data_out, 64'd0);
        checkOutput("idleMemAddr", lsuBus.mem_address_out, 64'd0);
        checkOutput("idleMemData", lsuBus.mem_data_out, 64'd0);
        checkOutput("idleWe", 64'(lsuBus.mem_writeEnable_out), 64'd0);
        checkOutput("idleRe", 64'(lsuBus.mem_readEnable_out), 64'd0);
    endtask

    // Issue one request (caller sits on a negedge) and check it against the reference memory.
    task automatic applyStimulus(input logic isStore, input logic [2:0] f3, input logic [63:0] addr,
                                 input logic [63:0] data, output logic [63:0] gotLoad, output logic gotErr);
        int          size, off, base, waitCycles, respCycle, readCycles, writeCycles, bothHigh;
        int          expLat, expReads, expWrites;
        logic        expErr, readyAfter, respAfter;
        logic [63:0] expLoad, alignedAddr, rdAddr, wrAddr;
        size        = 1 << f3[1:0];
        off         = int'(addr[2:0]);
        base        = int'(addr[7:3]) * 8;
        alignedAddr = {addr[63:3], 3'b000};
        expErr      = isStore ? f3[2] : (f3 == 3'b111);
`ifdef LSU_MISALIGN_CHECK_EN
        if ((off % size) != 0) expErr = 1'b1;
`else
        off = off - (off % size);
`endif
        expLoad = '0;
        if (!expErr && !isStore) begin
            for (int i = 0; i < size; i++) expLoad |= 64'(refBytes[base + off + i]) << (8 * i);
            if (!f3[2] && size < 8 && expLoad[8 * size - 1]) expLoad |= ~64'd0 << (8 * size);
        end
        if (expErr)                 expLat = 2;
        else if (!isStore)          expLat = 4;
        else if (f3[1:0] == 2'b11)  expLat = 3;
        else                        expLat = 5;
        expReads  = (!expErr && (!isStore || f3[1:0] != 2'b11)) ? 2 : 0;
        expWrites = (!expErr && isStore) ? 1 : 0;

        waitCycles = 0;
        while (!lsuBus.req_ready_out && waitCycles < 20) begin
            @(negedge clk);
            waitCycles++;
        end
        checkOutput("readyBeforeReq", 64'(lsuBus.req_ready_out), 64'd1);
        lsuBus.req_valid_in   = 1'b1;
        lsuBus.is_store_in    = isStore;
        lsuBus.funct3_in      = f3;
        lsuBus.addr_in        = addr;
        lsuBus.store_data_in  = data;
        @(posedge clk);
        #1 lsuBus.req_valid_in = 1'b0;

        respCycle = 0; readCycles = 0; writeCycles = 0; bothHigh = 0;
        readyAfter = 1'b0; respAfter = 1'b1; gotLoad = '0; gotErr = 1'b0;
        rdAddr = '0; wrAddr = '0;
        for (int n = 1; n <= 12; n++) begin
            @(negedge clk);
            if (lsuBus.mem_readEnable_out) begin
                readCycles++;
                rdAddr = lsuBus.mem_address_out;
            end
            if (lsuBus.mem_writeEnable_out) begin
                writeCycles++;
                wrAddr = lsuBus.mem_address_out;
            end
            if (lsuBus.mem_readEnable_out && lsuBus.mem_writeEnable_out) bothHigh++;
            if (respCycle != 0 && n == respCycle + 1) begin
                readyAfter = lsuBus.req_ready_out;
                respAfter  = lsuBus.resp_valid_out;
                break;
            end
            if (lsuBus.resp_valid_out && respCycle == 0) begin
                respCycle = n;
                gotLoad   = lsuBus.load_data_out;
                gotErr    = lsuBus.error_out;
            end
        end

        if (!expErr && isStore)
            for (int i = 0; i < size; i++) refBytes[base + off + i] = data[8 * i +: 8];

        checkOutput("latency", 64'(respCycle), 64'(expLat));
        checkOutput("error", 64'(gotErr), 64'(expErr));
        checkOutput("loadData", gotLoad, expLoad);
        checkOutput("readCycles", 64'(readCycles), 64'(expReads));
        checkOutput("writeCycles", 64'(writeCycles), 64'(expWrites));
        checkOutput("strobeOverlap", 64'(bothHigh), 64'd0);
        checkOutput("respPulse", 64'(respAfter), 64'd0);
        checkOutput("readyAfterResp", 64'(readyAfter), 64'd1);
        if (expReads > 0)  checkOutput("readAddr", rdAddr, alignedAddr);
        if (expWrites > 0) checkOutput("writeAddr", wrAddr, alignedAddr);
        checkOutput("memWord", dutMem[addr[7:3]], refWord(int'(addr[7:3])));
    endtask

    initial begin
        #500000;
        $display("[TB] FAIL watchdog: observed timeout, expected completion");
        $fatal(1, "[TB] simulation did not complete");
    end

    initial begin
        logic [63:0] lv;
        logic        le;
        int          accepts;
        int          resps;
        checks = 0;
        errors = 0;
        rstN   = 1'b0;
        preloadEn = 1'b0; preloadIdx = '0; preloadVal = '0;
        lsuBus.req_valid_in = 1'b0; lsuBus.is_store_in = 1'b0; lsuBus.funct3_in = '0;
        lsuBus.addr_in = '0; lsuBus.store_data_in = '0;

        for (int w = 0; w < 32; w++) loadWord(w, {$urandom, $urandom});
        checkIdleOutputs();
        rstN = 1'b1;
        @(negedge clk);

        applyStimulus(1'b1, 3'b011, 64'h10, 64'h1122334455667788, lv, le);
        applyStimulus(1'b0, 3'b011, 64'h10, 64'h0, lv, le);
        checkOutput("ldAfterSd", lv, 64'h1122334455667788);
        checkOutput("ldAfterSdErr", 64'(le), 64'd0);

        applyStimulus(1'b1, 3'b000, 64'h13, 64'hAB, lv, le);
        checkOutput("sbMerge", dutMem[2], 64'h11223344AB667788);

        loadWord(1, 64'h00000000F0008000);
        applyStimulus(1'b0, 3'b001, 64'h08, 64'h0, lv, le);
        checkOutput("lhSign", lv, 64'hFFFFFFFFFFFF8000);
        applyStimulus(1'b0, 3'b101, 64'h08, 64'h0, lv, le);
        checkOutput("lhuZero", lv, 64'h0000000000008000);
        applyStimulus(1'b0, 3'b010, 64'h0C, 64'h0, lv, le);
        checkOutput("lwUpper", lv, 64'h0000000000000000);
        applyStimulus(1'b0, 3'b110, 64'h08, 64'h0, lv, le);
        checkOutput("lwuLower", lv, 64'h00000000F0008000);

        applyStimulus(1'b0, 3'b010, 64'h0A, 64'h0, lv, le);
`ifdef LSU_MISALIGN_CHECK_EN
        checkOutput("lwMisalignErr", 64'(le), 64'd1);
`else
        checkOutput("lwMisalignMasked", lv, 64'hFFFFFFFFF0008000);
`endif

        applyStimulus(1'b1, 3'b100, 64'h20, 64'h55, lv, le);
        checkOutput("illegalStoreErr", 64'(le), 64'd1);
        applyStimulus(1'b0, 3'b111, 64'h20, 64'h0, lv, le);
        checkOutput("illegalLoadErr", 64'(le), 64'd1);

        // Valid held high throughout: one accept per completed load, none while busy.
        accepts = 0;
        resps   = 0;
        lsuBus.req_valid_in = 1'b1; lsuBus.is_store_in = 1'b0;
        lsuBus.funct3_in = 3'b011; lsuBus.addr_in = 64'h10;
        for (int k = 0; k < 12; k++) begin
            if (lsuBus.req_valid_in && lsuBus.req_ready_out) accepts++;
            if (lsuBus.resp_valid_out) resps++;
            @(negedge clk);
        end
        lsuBus.req_valid_in = 1'b0;
        for (int k = 0; k < 10 && !lsuBus.req_ready_out; k++) begin
            if (lsuBus.resp_valid_out) resps++;
            @(negedge clk);
        end
        checkOutput("holdAccepts", 64'(accepts), 64'd3);
        checkOutput("holdResps", 64'(resps), 64'd3);

        lsuBus.req_valid_in = 1'b1; lsuBus.is_store_in = 1'b1;
        lsuBus.funct3_in = 3'b011; lsuBus.addr_in = 64'h18; lsuBus.store_data_in = 64'hDEADBEEFCAFEF00D;
        @(posedge clk);
        #1 lsuBus.req_valid_in = 1'b0;
        @(posedge clk);
        #2;
        checkOutput("weBeforeReset", 64'(lsuBus.mem_writeEnable_out), 64'd1);
        rstN = 1'b0;
        #1;
        checkOutput("weAfterReset", 64'(lsuBus.mem_writeEnable_out), 64'd0);
        @(negedge clk);
        @(negedge clk);
        checkIdleOutputs();
        rstN = 1'b1;
        resps = 0;
        for (int k = 0; k < 6; k++) begin
            @(negedge clk);
            if (lsuBus.resp_valid_out) resps++;
        end
        checkOutput("noRespAfterAbort", 64'(resps), 64'd0);
        checkOutput("memUnchangedAfterAbort", dutMem[3], refWord(3));

        for (int t = 0; t < 100; t++) begin
            applyStimulus(1'($urandom_range(0, 1)), 3'($urandom_range(0, 7)),
                          {$urandom, $urandom}, {$urandom, $urandom}, lv, le);
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
